irq_pend_ctrl: RTL and testbench

//  Interrupt front-end that feeds the priority-encode stage: captures rising edges on
//  N_SRC request lines into sticky pending bits, applies a mask, priority-selects the

---
 rtl/irq_pkg.sv | 11 +
 rtl/prio_sel.sv | 25 ++
 rtl/irq_pend_ctrl.sv | 146 ++++++++++++++
 tb/tb_irq_pend_ctrl.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// Shared types and defaults for the interrupt pending controller.
package irq_pkg;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_ACK = 1'b1
    } irq_state_t;

    localparam int unsigned N_SRC_DEFAULT = 4;

endpackage : irq_pkg

// File: rtl/prio_sel.sv
// Highest-index-wins priority encoder over the unmasked pending vector.
module prio_sel
    import irq_pkg::*;
#(
    parameter int unsigned N_SRC = N_SRC_DEFAULT,
    parameter int unsigned ID_W  = $clog2(N_SRC)
) (
    input  logic [N_SRC-1:0] req,
    output logic [ID_W-1:0]  id_o,
    output logic             any_o
);

    // Later (higher) indices overwrite earlier ones, so the top set bit wins.
    always_comb begin
        id_o  = '0;
        any_o = 1'b0;
        for (int i = 0; i < int'(N_SRC); i++) begin
            if (req[i]) begin
                id_o  = ID_W'(i);
                any_o = 1'b1;
            end
        end
    end

endmodule : prio_sel

// File: rtl/irq_pend_ctrl.sv
// Interrupt front-end: edge capture into sticky pending bits, masking,
// priority select and a held valid/id handshake towards the consumer.
// Build option: define IRQ_SYNC_EN to pass src through a 2-flop synchronizer.
module irq_pend_ctrl
    import irq_pkg::*;
#(
    parameter int unsigned N_SRC = N_SRC_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_SRC-1:0]         src,
    input  logic                     mask_we,
    input  logic [N_SRC-1:0]         mask_wdata,
    input  logic                     irq_ack,
    output logic                     irq_valid,
    output logic [$clog2(N_SRC)-1:0] irq_id,
    output logic [N_SRC-1:0]         pend,
    output logic [N_SRC-1:0]         mask
);

    localparam int unsigned ID_W = $clog2(N_SRC);

    // Edges that would fire before the sampling path holds a real prior value
    // (a line held high through reset) are suppressed for this many cycles.
`ifdef IRQ_SYNC_EN
    localparam int unsigned ARM_CYC = 3;
`else
    localparam int unsigned ARM_CYC = 1;
`endif

    logic [N_SRC-1:0] s;
    logic [N_SRC-1:0] src_q;
    logic [N_SRC-1:0] rise;
    logic [N_SRC-1:0] req;
    logic [N_SRC-1:0] clr;
    logic [ID_W-1:0]  sel;
    logic             sel_any;
    logic [1:0]       arm_cnt;
    logic             armed;

    irq_state_t       state, state_d;
    logic             valid_d;
    logic [ID_W-1:0]  id_d;
    logic             ack_fire_c;

`ifdef IRQ_SYNC_EN
    logic [N_SRC-1:0] sync1, sync2;

    // Two-flop synchronizer per request line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= src;
            sync2 <= sync1;
        end
    end

    assign s = sync2;
`else
    assign s = src;
`endif

    assign armed = (arm_cnt == 2'(ARM_CYC));
    assign rise  = armed ? (s & ~src_q) : '0;
    assign req   = pend & ~mask;
    assign clr   = ack_fire_c ? (N_SRC'(1) << irq_id) : '0;

    prio_sel #(
        .N_SRC (N_SRC),
        .ID_W  (ID_W)
    ) u_prio_sel (
        .req   (req),
        .id_o  (sel),
        .any_o (sel_any)
    );

    // Previous-sample register and post-reset arming counter for edge detect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_q   <= '0;
            arm_cnt <= '0;
        end else begin
            src_q <= s;
            if (!armed) begin
                arm_cnt <= arm_cnt + 2'd1;
            end
        end
    end

    // Sticky pending bits (a new rise beats a same-cycle clear) and mask.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend <= '0;
            mask <= '0;
        end else begin
            pend <= (pend & ~clr) | rise;
            if (mask_we) begin
                mask <= mask_wdata;
            end
        end
    end

    // FSM state and registered presentation outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            irq_valid <= 1'b0;
            irq_id    <= '0;
        end else begin
            state     <= state_d;
            irq_valid <= valid_d;
            irq_id    <= id_d;
        end
    end

    // Next-state: latch the winner in IDLE, hold it until acknowledged.
    always_comb begin
        state_d    = state;
        valid_d    = irq_valid;
        id_d       = irq_id;
        ack_fire_c = 1'b0;
        unique case (state)
            IDLE: begin
                if (sel_any) begin
                    id_d    = sel;
                    valid_d = 1'b1;
                    state_d = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (irq_ack) begin
                    ack_fire_c = 1'b1;
                    valid_d    = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

endmodule : irq_pend_ctrl

// File: tb/tb_irq_pend_ctrl.sv
// Directed bench for irq_pend_ctrl (default build: src used directly).
module tb_irq_pend_ctrl;

    localparam int unsigned N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] src;
    logic         mask_we;
    logic [N-1:0] mask_wdata;
    logic         irq_ack;
    logic         irq_valid;
    logic [1:0]   irq_id;
    logic [N-1:0] pend;
    logic [N-1:0] mask;

    int n_pass  = 0;
    int n_total = 0;

    irq_pend_ctrl #(.N_SRC(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .src        (src),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .irq_ack    (irq_ack),
        .irq_valid  (irq_valid),
        .irq_id     (irq_id),
        .pend       (pend),
        .mask       (mask)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst        = 1'b1;
        src        = 4'b1111;
        mask_we    = 1'b0;
        mask_wdata = '0;
        irq_ack    = 1'b0;

        // 1: reset with all lines high
        tick(); tick();
        check("rst_valid", 32'(irq_valid), 32'd0);
        check("rst_id",    32'(irq_id),    32'd0);
        check("rst_pend",  32'(pend),      32'd0);
        check("rst_mask",  32'(mask),      32'd0);
        rst = 1'b0;
        tick(); tick(); tick();
        check("held_high_pend",  32'(pend),      32'd0);
        check("held_high_valid", 32'(irq_valid), 32'd0);

        // 2: single source
        src = 4'b0000; tick();
        src = 4'b0100; tick();
        check("single_pend_1cyc",  32'(pend),      32'b0100);
        check("single_valid_1cyc", 32'(irq_valid), 32'd0);
        tick();
        check("single_valid", 32'(irq_valid), 32'd1);
        check("single_id",    32'(irq_id),    32'd2);
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        check("single_ack_pend",  32'(pend),      32'd0);
        check("single_ack_valid", 32'(irq_valid), 32'd0);
        tick();
        check("level_no_reset", 32'(pend), 32'd0);

        // 3: priority and hold
        src = 4'b0000; tick();
        src = 4'b0010; tick(); tick();
        check("prio_id1", 32'(irq_id), 32'd1);
        src = 4'b1010; tick();
        check("prio_pend",     32'(pend),      32'b1010);
        check("prio_hold_v",   32'(irq_valid), 32'd1);
        check("prio_hold_id",  32'(irq_id),    32'd1);
        tick();
        check("prio_hold_id2", 32'(irq_id),    32'd1);
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        check("prio_gap_valid", 32'(irq_valid), 32'd0);
        check("prio_gap_pend",  32'(pend),      32'b1000);
        tick();
        check("prio_next_valid", 32'(irq_valid), 32'd1);
        check("prio_next_id",    32'(irq_id),    32'd3);
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        check("prio_clear", 32'(pend), 32'd0);

        // 4: mask
        src = 4'b0000;
        mask_we = 1'b1; mask_wdata = 4'b1000; tick(); mask_we = 1'b0;
        check("mask_write", 32'(mask), 32'b1000);
        src = 4'b1001; tick();
        check("mask_pend", 32'(pend), 32'b1001);
        tick();
        check("mask_valid", 32'(irq_valid), 32'd1);
        check("mask_id0",   32'(irq_id),    32'd0);
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        tick();
        check("mask_no_irq",  32'(irq_valid), 32'd0);
        check("mask_pend_kept", 32'(pend),    32'b1000);
        mask_we = 1'b1; mask_wdata = 4'b0000; tick(); mask_we = 1'b0;
        tick();
        check("unmask_valid", 32'(irq_valid), 32'd1);
        check("unmask_id3",   32'(irq_id),    32'd3);
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        check("unmask_clear", 32'(pend), 32'd0);

        // 5: set/clear collision on the presented index
        src = 4'b0000;
        mask_we = 1'b1; mask_wdata = 4'b0001; tick(); mask_we = 1'b0;
        src = 4'b0100; tick(); tick();
        check("coll_id2", 32'(irq_id), 32'd2);
        src = 4'b0000; tick();
        src = 4'b0100; irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        check("coll_pend_kept", 32'(pend),      32'b0100);
        check("coll_gap",       32'(irq_valid), 32'd0);
        tick();
        check("coll_re_valid", 32'(irq_valid), 32'd1);
        check("coll_re_id",    32'(irq_id),    32'd2);

        // 6: async reset mid-cycle while waiting for ack, then stray ack
        src = 4'b0000;
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid", 32'(irq_valid), 32'd0);
        check("arst_id",    32'(irq_id),    32'd0);
        check("arst_pend",  32'(pend),      32'd0);
        check("arst_mask",  32'(mask),      32'd0);
        tick();
        rst = 1'b0;
        tick();
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        check("stray_ack_valid", 32'(irq_valid), 32'd0);
        check("stray_ack_pend",  32'(pend),      32'd0);
        tick();
        check("stray_ack_idle", 32'(irq_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_irq_pend_ctrl
